// File: rtl/sc_datamem_io.sv
// sc_datamem_io
//   Data memory with memory-mapped I/O for the single-cycle CPU.
//   Decode uses addr[7:0] only (aliases every 256 bytes, word accesses):
//     0x00-0x7C : RAM_WORDS x 32-bit read/write RAM, index addr[6:2]
//     0x80/84/88: write-only minute/second/centisecond BCD registers
//                 (datain[7:0]); the rest of 0x80-0xBC ignores writes;
//                 reads anywhere in 0x80-0xBC return 0
//     0xC0-0xFC : read-only {24'b0, in_port}; writes ignored
//   Ports:
//     clock, resetn           : clock, synchronous active-low reset
//     addr, datain, we        : CPU ALU result, store data, write enable
//     dataout                 : combinational load data
//     in_port                 : switch input
//     *_display_high/_low     : BCD digit nibbles to the 7-segment decoders
module sc_datamem_io #(
  parameter int unsigned RAM_WORDS = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  output logic [31:0] dataout,
  input  logic [7:0]  in_port,
  output logic [3:0]  minute_display_high,
  output logic [3:0]  minute_display_low,
  output logic [3:0]  second_display_high,
  output logic [3:0]  second_display_low,
  output logic [3:0]  msecond_display_high,
  output logic [3:0]  msecond_display_low
);

  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] ram_d [RAM_WORDS];
  logic [7:0]  minute_q, minute_d;
  logic [7:0]  second_q, second_d;
  logic [7:0]  msecond_q, msecond_d;

  logic [4:0]  ram_idx;
  logic        ram_idx_ok;
  logic        unused_addr_bits;

  assign ram_idx          = addr[6:2];
  assign ram_idx_ok       = (32'(ram_idx) < RAM_WORDS);
  assign unused_addr_bits = ^{addr[31:8], addr[1:0]};

  // Next-state: RAM writes only when addr[7]=0, display writes only at
  // word offsets 0x80/0x84/0x88 of the output region.
  always_comb begin
    ram_d     = ram_q;
    minute_d  = minute_q;
    second_d  = second_q;
    msecond_d = msecond_q;
    if (we) begin
      if (!addr[7]) begin
        if (ram_idx_ok) ram_d[ram_idx] = datain;
      end else if (!addr[6]) begin
        case (addr[5:2])
          4'h0:    minute_d  = datain[7:0];
          4'h1:    second_d  = datain[7:0];
          4'h2:    msecond_d = datain[7:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ram_q     <= '{default: '0};
      minute_q  <= '0;
      second_q  <= '0;
      msecond_q <= '0;
    end else begin
      ram_q     <= ram_d;
      minute_q  <= minute_d;
      second_q  <= second_d;
      msecond_q <= msecond_d;
    end
  end

  // Combinational load path; no bypass of a same-cycle write.
  always_comb begin
    dataout = '0;
    if (!addr[7]) begin
      if (ram_idx_ok) dataout = ram_q[ram_idx];
    end else if (addr[6]) begin
      dataout = {24'b0, in_port};
    end
  end

  assign minute_display_high  = minute_q[7:4];
  assign minute_display_low   = minute_q[3:0];
  assign second_display_high  = second_q[7:4];
  assign second_display_low   = second_q[3:0];
  assign msecond_display_high = msecond_q[7:4];
  assign msecond_display_low  = msecond_q[3:0];

endmodule

// File: tb/tb_sc_datamem_io.sv
// Testbench for sc_datamem_io: stimulus pushes expected responses into a
// scoreboard queue; a monitor samples the DUT mid-cycle and compares.
module tb_sc_datamem_io;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [31:0] dataout;
  logic [7:0]  in_port;
  logic [3:0]  mh, ml, sh, sl, ch, cl;

  sc_datamem_io #(.RAM_WORDS(32)) dut (
    .clock                (clock),
    .resetn               (resetn),
    .addr                 (addr),
    .datain               (datain),
    .we                   (we),
    .dataout              (dataout),
    .in_port              (in_port),
    .minute_display_high  (mh),
    .minute_display_low   (ml),
    .second_display_high  (sh),
    .second_display_low   (sl),
    .msecond_display_high (ch),
    .msecond_display_low  (cl)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic [23:0] digits;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: memory map described as plain arrays and bytes.
  bit [31:0] ram_m [32];
  bit [7:0]  min_m, sec_m, cs_m;

  function automatic logic [31:0] model_read(logic [31:0] a, logic [7:0] p);
    logic [7:0] off;
    off = a[7:0];
    if (off < 8'h80) return ram_m[off / 4];
    if (off < 8'hC0) return 32'h0;
    return {24'h0, p};
  endfunction

  function automatic void model_edge(logic rn, logic w, logic [31:0] a, logic [31:0] d);
    logic [7:0] off;
    off = a[7:0];
    if (!rn) begin
      foreach (ram_m[i]) ram_m[i] = 32'h0;
      min_m = 8'h0; sec_m = 8'h0; cs_m = 8'h0;
    end else if (w) begin
      if (off < 8'h80)                         ram_m[off / 4] = d;
      else if (off >= 8'h80 && off <= 8'h83)   min_m = d[7:0];
      else if (off >= 8'h84 && off <= 8'h87)   sec_m = d[7:0];
      else if (off >= 8'h88 && off <= 8'h8B)   cs_m  = d[7:0];
    end
  endfunction

  function automatic void push_exp(string nm);
    exp_t e;
    e.name   = nm;
    e.dout   = model_read(addr, in_port);
    e.digits = {min_m, sec_m, cs_m};
    q.push_back(e);
  endfunction

  // One CPU cycle: drive after the edge, record expectation (pre-edge
  // state), optionally change in_port mid-cycle with no clock edge.
  task automatic cycle(input logic rn, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [7:0] p,
                       input bit mid, input logic [7:0] p2, input string nm);
    @(posedge clock);
    #1;
    resetn = rn; we = w; addr = a; datain = d; in_port = p;
    push_exp(nm);
    if (mid) begin
      #5;
      in_port = p2;
      push_exp({nm, "_mid"});
    end
    model_edge(rn, w, a, d);
  endtask

  task automatic compare_one();
    exp_t e;
    logic [23:0] got;
    e   = q.pop_front();
    got = {mh, ml, sh, sl, ch, cl};
    checks++;
    if (dataout !== e.dout) begin
      errors++;
      $display("FAIL %s dataout: got %08h expected %08h", e.name, dataout, e.dout);
    end
    checks++;
    if (got !== e.digits) begin
      errors++;
      $display("FAIL %s digits: got %06h expected %06h", e.name, got, e.digits);
    end
  endtask

  // Monitor: sample at the falling edge and just before the rising edge.
  initial begin
    forever begin
      @(negedge clock);
      if (q.size() > 0) compare_one();
      #3;
      if (q.size() > 0) compare_one();
    end
  end

  initial begin
    resetn = 1'b0; we = 1'b0; addr = '0; datain = '0; in_port = '0;
    @(posedge clock);
    // Model starts cleared, matching the reset applied at that edge.

    cycle(1, 0, 32'h00, 0, 8'h00, 0, 0, "rst_ram00");
    cycle(1, 0, 32'h7C, 0, 8'h00, 0, 0, "rst_ram7c");
    cycle(1, 1, 32'h04, 32'hDEADBEEF, 8'h00, 0, 0, "wr04");
    cycle(1, 1, 32'h7C, 32'h12345678, 8'h00, 0, 0, "wr7c");
    cycle(1, 0, 32'h04, 0, 8'h00, 0, 0, "rd04");
    cycle(1, 0, 32'h7C, 0, 8'h00, 0, 0, "rd7c");
    cycle(1, 0, 32'h00, 0, 8'h00, 0, 0, "rd00");
    cycle(1, 0, 32'h104, 0, 8'h00, 0, 0, "rd104_alias");
    cycle(1, 1, 32'h80, 32'h59, 8'h00, 0, 0, "wr_min");
    cycle(1, 1, 32'h84, 32'h34, 8'h00, 0, 0, "wr_sec");
    cycle(1, 1, 32'h88, 32'h07, 8'h00, 0, 0, "wr_cs");
    cycle(1, 0, 32'h00, 0, 8'h00, 0, 0, "disp_ram00");
    cycle(1, 0, 32'h04, 0, 8'h00, 0, 0, "disp_ram04");
    cycle(1, 0, 32'h80, 0, 8'h00, 0, 0, "rd80_zero");
    cycle(1, 1, 32'h8C, 32'hFF, 8'h00, 0, 0, "wr8c_ignored");
    cycle(1, 0, 32'hC0, 0, 8'hA5, 1, 8'h3C, "inport");
    cycle(1, 1, 32'hC0, 32'hFFFFFFFF, 8'h3C, 0, 0, "wr_c0_ignored");
    cycle(1, 0, 32'h00, 0, 8'h3C, 0, 0, "after_c0_ram00");
    cycle(1, 1, 32'h08, 32'hAAAA5555, 8'h00, 0, 0, "wr08");
    cycle(0, 1, 32'h80, 32'hFF, 8'h00, 0, 0, "rstpri_min");
    cycle(0, 1, 32'h08, 32'hFF, 8'h00, 0, 0, "rstpri_ram");
    cycle(1, 0, 32'h08, 0, 8'h00, 0, 0, "after_rst08");
    cycle(1, 1, 32'h10, 32'h1, 8'h00, 0, 0, "rdw_init");
    cycle(1, 1, 32'h10, 32'h2, 8'h00, 0, 0, "rdw_before");
    cycle(1, 0, 32'h10, 0, 8'h00, 0, 0, "rdw_after");

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic        rn;
      a  = $urandom;
      rn = ($urandom_range(0, 49) != 0);
      case ($urandom_range(0, 3))
        0: a[7:2] = 6'h20 + 6'($urandom_range(0, 3));
        1: a[7]   = 1'b0;
        default: ;
      endcase
      cycle(rn, 1'($urandom_range(0, 1)), a, $urandom, 8'($urandom),
            ($urandom_range(0, 7) == 0), 8'($urandom), "rand");
    end

    @(posedge clock);
    @(posedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_datamem_io.md
# sc_datamem_io

Data memory with memory-mapped I/O for the single-cycle CPU (`sc_cpu`).
- Provides 32 words of read/write RAM.
- Provides one 8-bit input port (switches).
- Provides three write-only BCD display registers (minutes, seconds, centiseconds) that drive six 4-bit digit outputs to the seven-segment decoders.
- Sits between the CPU's ALU-result/store-data buses and the board I/O; reads are combinational so a load completes within one CPU cycle.

## Interface
Parameters:
- `RAM_WORDS`, default 32: number of 32-bit RAM words; addressed by `addr[6:2]`.

Ports:
- `clock`  in  1: the single clock; all state updates on its rising edge.
- `resetn`  in  1: reset, synchronous and active-low.
- `addr`  in  32: byte address (the CPU ALU result).
- `datain`  in  32: store data.
- `we`  in  1: write enable (CPU `wmem`).
- `dataout`  out  32: load data, combinational.
- `in_port`  in  8: external switch input.
- `minute_display_high`, `minute_display_low`  out  4 each: minute BCD digits.
- `second_display_high`, `second_display_low`  out  4 each: second BCD digits.
- `msecond_display_high`, `msecond_display_low`  out  4 each: centisecond BCD digits.

## Operation
- Decode uses `addr[7:0]` only.
  - `addr[31:8]` is ignored, so addresses alias every 256 bytes.
  - `addr[1:0]` is ignored; all accesses are word accesses.
- RAM region, `addr[7]=0` (0x00–0x7C):
  - Read: `dataout = ram[addr[6:2]]`.
  - Write: when `we=1`, `ram[addr[6:2]] <= datain`.
- Output region, `addr[7:6]=10`:
  - 0x80: `we=1` loads the minute register from `datain[7:0]`. High nibble drives `minute_display_high`; low nibble drives `minute_display_low`.
  - 0x84: same, for the second register.
  - 0x88: same, for the centisecond register.
  - 0x8C–0xBC: writes are ignored.
  - Reads anywhere in this region return 0.
- Input region, `addr[7:6]=11`:
  - Read returns `{24'b0, in_port}` combinationally.
  - Writes are ignored.
- A write never alters RAM when `addr[7]=1`, and never alters display registers when `addr[7]=0`.
- Nibbles are passed through unchanged. Values above 9 are not checked or corrected; the seven-segment decoder handles them.
- Display outputs are driven directly from their registers, with no combinational path from `datain`.

## Timing
- Reset: when `resetn=0` at a rising edge:
  - All RAM words are cleared to 0.
  - All three display registers are cleared to 0, so all six digit outputs read 0.
  - Reset has priority over a simultaneous `we=1`; that write is discarded.
- Write latency:
  - A write takes effect at the rising edge where `we=1`.
  - The new RAM value appears on `dataout` immediately after that edge, if the address is unchanged.
  - New display values appear on the digit outputs immediately after the same edge.
- Read latency is zero cycles: `dataout` follows `addr`, RAM contents and `in_port` combinationally.
- Read during write, same address: before the edge `dataout` shows the old value; after the edge it shows the new value. No bypass is applied.
- `in_port` is sampled without synchronisation. It is treated as quasi-static switch input, stable over the access cycle.

## Test plan
- Reset: hold `resetn=0` for 1 cycle, release -> every digit output is 0; reading 0x00 and 0x7C gives `dataout=0`.
- RAM write/read:
  - Write 0xDEADBEEF to 0x04, then 0x12345678 to 0x7C.
  - Reading 0x04 gives 0xDEADBEEF; 0x7C gives 0x12345678; 0x00 stays 0.
  - Reading 0x104 aliases 0x04 and gives 0xDEADBEEF.
- Displays:
  - Write 0x59 to 0x80, 0x34 to 0x84 and 0x07 to 0x88.
  - Digit outputs read 5,9 / 3,4 / 0,7 (high,low).
  - RAM words 0x00 and 0x04 are unchanged.
  - Reading 0x80 gives 0.
- Input port: `in_port`=0xA5, read 0xC0 -> `dataout`=0x000000A5. Change to 0x3C with no clock edge -> `dataout`=0x0000003C. A write to 0xC0 changes nothing.
- Reset priority: `resetn=0` with `we=1` writing 0xFF to 0x80 and to 0x08 -> after the edge, the minute digits are 0,0 and RAM at 0x08 is 0.
- Read during write: `addr`=0x10 holding 0x1, `we=1`, `datain`=0x2 -> `dataout`=0x1 before the edge and 0x2 after it.
